divclk_sched: RTL and testbench

DIVCLK_SCHED -- requirements
Module: divclk_sched

---
 rtl/divclk_sched_if.sv | 32 +++
 rtl/divclk_sched.sv | 141 ++++++++++++++
 tb/tb_divclk_sched.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/divclk_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : divclk_sched_if
// Description : Request/grant and divided-clock-enable bundle for
//               divclk_sched. The master drives requests and configuration.
//               The slave (the scheduler) returns grant, tick, count and busy.
// Revision    : 1.0 - initial release
// ============================================================================
interface divclk_sched_if #(
    parameter int NREQ   = 4,
    parameter int DIVW   = 8,
    parameter int BURSTW = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DIVW-1:0] div_ratio;
    logic [BURSTW-1:0]    burst_len;
    logic [NREQ-1:0]      gnt;
    logic                 tick;
    logic [DIVW-1:0]      count;
    logic                 busy;

    modport master (
        output req, div_ratio, burst_len,
        input  gnt, tick, count, busy
    );

    modport slave (
        input  req, div_ratio, burst_len,
        output gnt, tick, count, busy
    );
endinterface
`default_nettype wire

// File: rtl/divclk_sched.sv
`default_nettype none
// ============================================================================
// Module      : divclk_sched
// Description : Arbitrated clock divider. Grants one requester at a time,
//               then produces burst_len divided-clock-enable ticks at that
//               requester's divide ratio. A single GAP cycle follows before
//               the next arbitration. The default build uses round-robin
//               arbitration. Defining DIVCLK_SCHED_PRIO_EN selects fixed
//               priority with req[0] highest.
// Revision    : 1.0 - initial release
// ============================================================================
module divclk_sched #(
    parameter int NREQ   = 4,
    parameter int DIVW   = 8,
    parameter int BURSTW = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    divclk_sched_if.slave   bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    logic [NREQ-1:0]    r_gnt;
    logic [IDXW-1:0]    r_gidx;
    logic [IDXW-1:0]    r_last;
    logic [DIVW-1:0]    r_count;
    logic [DIVW-1:0]    r_ratio;
    logic [BURSTW-1:0]  r_burst;
    logic [BURSTW-1:0]  r_done;
    logic               r_busy;

    logic [IDXW-1:0]    w_win_idx;
    logic               w_any_req;
    logic [DIVW-1:0]    w_ratio_sel;
    logic               w_req_g;
    logic               w_at_wrap;
    logic               w_burst_last;
    logic               w_tick;

    assign w_any_req    = |bus.req;
    assign w_ratio_sel  = bus.div_ratio[int'(w_win_idx)*DIVW +: DIVW];
    assign w_req_g      = bus.req[r_gidx];
    assign w_at_wrap    = (r_count == (r_ratio - DIVW'(1)));
    assign w_burst_last = (r_done == (r_burst - BURSTW'(1)));
    // tick is masked by rst so it stays low for the whole reset cycle
    assign w_tick       = (r_state == S_RUN) && w_at_wrap && w_req_g && !rst;

    assign bus.gnt   = r_gnt;
    assign bus.tick  = w_tick;
    assign bus.count = r_count;
    assign bus.busy  = r_busy;

    // Winner selection; descending loops let the preferred candidate overwrite last
    always_comb begin
        w_win_idx = '0;
`ifdef DIVCLK_SCHED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                w_win_idx = IDXW'(k);
            end
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            if (bus.req[(int'(r_last) + k) % NREQ]) begin
                w_win_idx = IDXW'((int'(r_last) + k) % NREQ);
            end
        end
`endif
    end

    // Scheduler FSM: IDLE arbitrates, RUN divides and counts ticks, GAP retires the grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_last  <= IDXW'(NREQ - 1);
            r_count <= '0;
            r_ratio <= DIVW'(1);
            r_burst <= BURSTW'(1);
            r_done  <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                        r_gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;
                        r_gidx  <= w_win_idx;
                        r_ratio <= (w_ratio_sel == '0) ? DIVW'(1) : w_ratio_sel;
                        r_burst <= (bus.burst_len == '0) ? BURSTW'(1) : bus.burst_len;
                        r_count <= '0;
                        r_done  <= '0;
                    end
                end
                S_RUN: begin
                    if (!w_req_g) begin
                        // requester withdrew: abort without a tick
                        r_state <= S_GAP;
                        r_gnt   <= '0;
                        r_count <= '0;
                    end else if (w_at_wrap) begin
                        r_count <= '0;
                        if (w_burst_last) begin
                            r_state <= S_GAP;
                            r_gnt   <= '0;
                        end else begin
                            r_done <= r_done + BURSTW'(1);
                        end
                    end else begin
                        r_count <= r_count + DIVW'(1);
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                    r_last  <= r_gidx;
                    r_gnt   <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= '0;
                    r_count <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_divclk_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_divclk_sched
// Description : Self-checking bench for divclk_sched. A cycle-level
//               behavioural model checks every output on every cycle. Directed
//               scenarios pin hand-derived values, and a randomized phase
//               follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divclk_sched;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divclk_sched_if #(.NREQ(4), .DIVW(8), .BURSTW(4)) bus ();

    divclk_sched #(.NREQ(4), .DIVW(8), .BURSTW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 idle, 1 running a grant, 2 gap; m_cyc = cycles spent in the grant
    int m_st = 0, m_g = 0, m_last = 3, m_ratio = 1, m_burst = 1, m_cyc = 0, m_ticks = 0;
    bit m_valid = 0;

    function automatic int pick(input logic [3:0] r, input int last);
`ifdef DIVCLK_SCHED_PRIO_EN
        for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
        for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
`endif
        return 0;
    endfunction

    function automatic int clamp1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit exp_tick();
        return (m_st == 1) && ((m_cyc % m_ratio) == m_ratio - 1) && (bus.req[m_g] == 1'b1) && !rst;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_st    <= 0;
            m_last  <= 3;
            m_cyc   <= 0;
            m_ticks <= 0;
            m_valid <= 1;
        end else begin
            case (m_st)
                0: if (bus.req != 4'b0) begin
                    m_st    <= 1;
                    m_g     <= pick(bus.req, m_last);
                    m_ratio <= clamp1(int'(bus.div_ratio[pick(bus.req, m_last)*8 +: 8]));
                    m_burst <= clamp1(int'(bus.burst_len));
                    m_cyc   <= 0;
                    m_ticks <= 0;
                end
                1: begin
                    if (bus.req[m_g] != 1'b1) m_st <= 2;
                    else if (exp_tick()) begin
                        if (m_ticks + 1 == m_burst) m_st <= 2;
                        else begin
                            m_ticks <= m_ticks + 1;
                            m_cyc   <= m_cyc + 1;
                        end
                    end else m_cyc <= m_cyc + 1;
                end
                default: begin
                    m_last <= m_g;
                    m_st   <= 0;
                end
            endcase
        end
    end

    // Compare process: all outputs against the model on every cycle after the first reset
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_gnt",   bus.gnt,   (m_st == 1) ? (32'd1 << m_g) : 32'd0);
            chk("m_count", bus.count, (m_st == 1) ? (m_cyc % m_ratio) : 0);
            chk("m_busy",  bus.busy,  (m_st != 0) ? 1 : 0);
            chk("m_tick",  bus.tick,  exp_tick() ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] exp_rr [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [3:0] r;
`ifdef DIVCLK_SCHED_PRIO_EN
        exp_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        rst = 1'b1;
        bus.req = '0; bus.div_ratio = '0; bus.burst_len = '0;
        repeat (3) cyc();
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_tick", bus.tick, 0);
        rst = 1'b0;

        // Basic: ratio 3, burst 2 -> ticks in cycles 3 and 6, GAP 7, IDLE 8
        bus.req = 4'b0001; bus.div_ratio = 32'h0000_0003; bus.burst_len = 4'd2;
        cyc(); chk("basic_gnt_c1", bus.gnt, 4'b0001); chk("basic_tick_c1", bus.tick, 0);
        cyc(); chk("basic_tick_c2", bus.tick, 0);
        cyc(); chk("basic_tick_c3", bus.tick, 1); chk("basic_count_c3", bus.count, 2);
        cyc(); chk("basic_tick_c4", bus.tick, 0);
        cyc();
        cyc(); chk("basic_tick_c6", bus.tick, 1);
        cyc(); chk("basic_gap_gnt", bus.gnt, 0); chk("basic_gap_busy", bus.busy, 1);
        bus.req = 4'b0000;
        cyc(); chk("basic_idle_busy", bus.busy, 0);

        // Round-robin / priority sequence from a fresh reset
        rst = 1'b1; cyc(); rst = 1'b0;
        bus.req = 4'hF; bus.div_ratio = 32'h0202_0202; bus.burst_len = 4'd1;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (bus.gnt == 4'b0 && w < 10) begin cyc(); w++; end
            chk("rr_gnt", bus.gnt, exp_rr[g]);
            w = 0;
            while (bus.gnt != 4'b0 && w < 10) begin cyc(); w++; end
            chk("rr_release", bus.gnt, 0);
        end
        bus.req = 4'b0; repeat (4) cyc();

        // Abort: ratio 5, burst 3, drop the request after the first tick
        bus.req = 4'b0100; bus.div_ratio = 32'h0005_0000; bus.burst_len = 4'd3;
        cyc(); chk("abort_gnt", bus.gnt, 4'b0100);
        repeat (3) cyc(); chk("abort_tick_c4", bus.tick, 0);
        cyc(); chk("abort_tick_c5", bus.tick, 1);
        cyc(); bus.req = 4'b0000; #1 chk("abort_tick_drop", bus.tick, 0);
        cyc(); chk("abort_gap_gnt", bus.gnt, 0); chk("abort_gap_busy", bus.busy, 1);
        chk("abort_gap_tick", bus.tick, 0);
        cyc(); chk("abort_idle", bus.busy, 0);

        // Zero ratio and burst behave as 1
        bus.req = 4'b0001; bus.div_ratio = 32'h0; bus.burst_len = 4'd0;
        cyc(); chk("zero_gnt", bus.gnt, 4'b0001); chk("zero_tick", bus.tick, 1);
        cyc(); chk("zero_gap_gnt", bus.gnt, 0); chk("zero_gap_tick", bus.tick, 0);
        bus.req = 4'b0; repeat (2) cyc();

        // Reset mid-RUN while count == 2
        bus.req = 4'b0001; bus.div_ratio = 32'h0000_0006; bus.burst_len = 4'd1;
        cyc(); cyc(); cyc(); chk("mid_count", bus.count, 2);
        rst = 1'b1;
        cyc(); chk("mid_gnt", bus.gnt, 0); chk("mid_count0", bus.count, 0);
        chk("mid_busy", bus.busy, 0); chk("mid_tick", bus.tick, 0);
        rst = 1'b0; bus.req = 4'hF; bus.div_ratio = 32'h0202_0202;
        cyc(); chk("mid_restart", bus.gnt, 4'b0001);
        bus.req = 4'b0; repeat (4) cyc();

        // Ratio change during a grant does not affect tick spacing
        bus.req = 4'b0001; bus.div_ratio = 32'h0000_0002; bus.burst_len = 4'd3;
        cyc(); bus.div_ratio = 32'h0000_0007;
        cyc(); chk("chg_tick_c2", bus.tick, 1);
        cyc(); chk("chg_tick_c3", bus.tick, 0);
        cyc(); chk("chg_tick_c4", bus.tick, 1);
        bus.req = 4'b0; repeat (4) cyc();

        // Randomized phase: level-held requests, occasional config changes and resets
        for (int i = 0; i < 4000; i++) begin
            r = bus.req;
            for (int b = 0; b < 4; b++) if ($urandom_range(15) == 0) r[b] = ~r[b];
            bus.req = r;
            if ($urandom_range(31) == 0)
                bus.div_ratio = {8'($urandom_range(4)), 8'($urandom_range(4)),
                                 8'($urandom_range(4)), 8'($urandom_range(4))};
            if ($urandom_range(31) == 0) bus.burst_len = 4'($urandom_range(3));
            rst = ($urandom_range(299) == 0);
            cyc();
        end
        rst = 1'b0;
        repeat (2) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
